// File: rtl/pipo_pkg.sv
// ============================================================================
// Module : pipo_pkg
// Brief  : Shared constants for the pipo holding register and its output buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipo_pkg;
  localparam int unsigned PIPO_DEFAULT_WIDTH = 8;
endpackage : pipo_pkg

`default_nettype wire

// File: rtl/pipo_obuf.sv
// ============================================================================
// Module : pipo_obuf
// Brief  : WIDTH-bit tri-state buffer with a single active-low enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipo_obuf
  import pipo_pkg::*;
#(
  parameter int unsigned WIDTH = PIPO_DEFAULT_WIDTH
) (
  input  wire logic [WIDTH-1:0] d,
  input  wire logic             oe_n,
  output tri        [WIDTH-1:0] y
);

  assign y = oe_n ? {WIDTH{1'bz}} : d;

endmodule : pipo_obuf

`default_nettype wire

// File: rtl/pipo.sv
// ============================================================================
// Module : pipo
// Brief  : Parallel-in/parallel-out holding register with tri-state bus output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipo
  import pipo_pkg::*;
#(
  parameter int unsigned WIDTH       = PIPO_DEFAULT_WIDTH,
  parameter              RESET_VALUE = {WIDTH{1'b0}}
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             oe_n,
  input  wire logic             le,
  input  wire logic [WIDTH-1:0] in,
  output tri        [WIDTH-1:0] out,
  output logic      [WIDTH-1:0] q,
  output logic                  loaded
);

  // Reject a reset word whose width does not match the data path.
  if (WIDTH < 1 || $bits(RESET_VALUE) != WIDTH) begin : g_bad_reset_value
    $error("pipo: RESET_VALUE width must equal WIDTH (>=1)");
  end

  localparam logic [WIDTH-1:0] C_RESET_WORD = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] store_q, store_d;
  logic             loaded_q, loaded_d;

  always_comb begin
    store_d  = store_q;
    loaded_d = loaded_q;
    if (le) begin
      store_d  = in;
      loaded_d = 1'b1;
    end
  end

  // Reset outranks a simultaneous load.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q  <= C_RESET_WORD;
      loaded_q <= 1'b0;
    end else begin
      store_q  <= store_d;
      loaded_q <= loaded_d;
    end
  end

  assign q      = store_q;
  assign loaded = loaded_q;

  pipo_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .d    (store_q),
    .oe_n (oe_n),
    .y    (out)
  );

endmodule : pipo

`default_nettype wire

// File: tb/tb_pipo.sv
// Bench for pipo: directed vector table, hand sequences and randomized run against a model.
// The out bus is pulled up, so a released (Z) bus reads back as all ones.
`default_nettype none

module tb_pipo;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         oe_n = 1'b1;
  logic         le = 1'b0;
  logic [W-1:0] din = '0;
  wire  [W-1:0] bus;
  logic [W-1:0] q;
  logic         loaded;

  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup (bus[i]);
  end

  pipo #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .oe_n   (oe_n),
    .le     (le),
    .in     (din),
    .out    (bus),
    .q      (q),
    .loaded (loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the word the register should hold and whether it was loaded.
  logic [W-1:0] m_store;
  logic         m_loaded;

  typedef struct {
    logic         rst;
    logic         le;
    logic         oe_n;
    logic [W-1:0] din;
    logic [W-1:0] exp_q;
    logic         exp_loaded;
    logic [W-1:0] exp_bus;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic o, input logic [W-1:0] d);
    @(negedge clk);
    rst = r; le = l; oe_n = o; din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] bus_of(input logic o, input logic [W-1:0] s);
    return o ? {W{1'b1}} : s;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'hFF};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h55, 1'b1, 8'h55};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h55, 1'b1, 8'h55};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 1'b1, 8'h55};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 1'b1, 8'h55};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hAA, 8'hAA, 1'b1, 8'hAA};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 1'b1, 8'hFF};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 1'b1, 8'hAA};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C, 1'b1, 8'hFF};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, 8'h3C};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h11, 1'b1, 8'h11};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h22, 1'b1, 8'h22};

    // Reset with output released, then enable without a clock edge.
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check("reset_q", q, 8'h00);
    check("reset_loaded", {7'b0, loaded}, 8'h00);
    check("reset_bus_z", bus, 8'hFF);
    oe_n = 1'b0; #1;
    check("reset_bus_enabled", bus, 8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].le, vecs[i].oe_n, vecs[i].din);
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_loaded", i), {7'b0, loaded}, {7'b0, vecs[i].exp_loaded});
      check($sformatf("vec%0d_bus", i), bus, vecs[i].exp_bus);
    end

    // Ten idle cycles with a changing input must not disturb the held word.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'(i * 37 + 1));
      check("hold_bus", bus, 8'h22);
    end

    // Output enable is combinational: toggle between edges.
    @(negedge clk);
    oe_n = 1'b1; #1;
    check("oe_off_comb", bus, 8'hFF);
    check("oe_off_q", q, 8'h22);
    oe_n = 1'b0; #1;
    check("oe_on_comb", bus, 8'h22);

    // Randomized run against the model.
    m_store = 8'h22;
    m_loaded = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic         r, l, o;
      logic [W-1:0] d;
      r = ($urandom_range(0, 15) == 0);
      l = $urandom_range(0, 1) == 1;
      o = $urandom_range(0, 3) == 0;
      d = 8'($urandom);
      step(r, l, o, d);
      if (r) begin
        m_store = 8'h00;
        m_loaded = 1'b0;
      end else if (l) begin
        m_store = d;
        m_loaded = 1'b1;
      end
      check("rand_q", q, m_store);
      check("rand_loaded", {7'b0, loaded}, {7'b0, m_loaded});
      check("rand_bus", bus, bus_of(o, m_store));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipo

`default_nettype wire

// File: doc/pipo.md
# pipo

Parameterised parallel-in/parallel-out holding register with a tri-state output. Captures a WIDTH-bit input word on a clock edge when the latch-enable is high, holds it indefinitely, and drives it onto a shared bus only while the active-low output enable is asserted. Used wherever a word must be sampled from one bus and later presented on another shared (multi-driver) bus.

## Interface
- WIDTH, 8, data width in bits (≥1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the holding register by reset
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- oe_n  input  1  output enable, active-low; 1 = out high-impedance
- le  input  1  latch (load) enable, active-high, sampled on rising clk
- in  input  WIDTH  parallel data in
- out  output (tri)  WIDTH  parallel data out; held word when oe_n=0, all-Z when oe_n=1
- q  output  WIDTH  held word, always driven (internal readback, unaffected by oe_n)
- loaded  output  1  1 once any word has been captured since last reset

## Operation
- Holding register `store` (WIDTH bits) and flag `loaded`.
- Rising clk, priority order:
  - rst=1: store <= RESET_VALUE, loaded <= 0 (le and in ignored).
  - else le=1: store <= in, loaded <= 1.
  - else: store and loaded hold.
- q = store, continuously.
- out = oe_n ? {WIDTH{1'bz}} : store. Purely combinational in oe_n; no per-bit enables.
- Changes on `in` while le=0 never reach store, q or out.
- le held high for several cycles re-captures `in` every edge (register tracks `in` with one-cycle delay).
- oe_n has no effect on capture; a word may be loaded while out is Z and appears on out as soon as oe_n falls.

## Timing
- Capture latency: 1 cycle. Word present on `in` at rising edge N with le=1 appears on q (and on out if oe_n=0) immediately after edge N.
- Output-enable path: zero cycles; out goes Z/driven combinationally with oe_n.
- Reset values after a rst edge: q = RESET_VALUE, loaded = 0; out = RESET_VALUE if oe_n=0, else all-Z.
- Before the first reset edge, store/q are undefined (X); out is Z whenever oe_n=1 regardless.
- rst and le both high on the same edge: reset wins.
- rst asserted mid-hold: register cleared on that edge; previously held word is lost.
- le deasserted and `in` changed on the same edge: value sampled is the pre-edge `in` (standard setup/hold).

## Structure
- No shared package required; WIDTH and RESET_VALUE are module parameters only.
- One natural sub-module: pipo_obuf (WIDTH-parameterised tri-state buffer: input d, enable-low oe_n, output y), instantiated once for the out port; store/loaded logic lives in pipo itself.
- RESET_VALUE must be checked width-compatible with WIDTH at elaboration.

## Test plan
- Reset: oe_n=1, rst=1 for one edge -> q=0x00, loaded=0, out=ZZ; then oe_n=0 -> out=0x00 with no clock edge needed.
- Basic load: in=0x55, le=1 for one edge, oe_n=0 -> out=0x55, q=0x55, loaded=1; then le=0, in=0x00 for 10 cycles -> out stays 0x55.
- Reload: in=0xAA, le=0 for 2 cycles -> out stays 0x55; le=1 one edge -> out=0xAA after that edge.
- Output disable: with store=0xAA, oe_n=1 -> out=ZZ immediately, q=0xAA; oe_n=0 again -> out=0xAA, no reload.
- Priority: store=0xAA, rst=1 and le=1 with in=0x55 on same edge -> q=0x00, loaded=0.
- Load while disabled: oe_n=1, in=0x3C, le=1 one edge -> out=ZZ, q=0x3C; oe_n=0 -> out=0x3C.
